// File: rtl/iter_divider.sv
`default_nettype none
// ------------------------------------------------------------------------
// iter_divider: radix-2 restoring DIV/DIVU, result WIDTH+2 cycles after start.
// Optional macro DIV_ZERO_FAST_EN: zero divisor skips the iterations. Rev 1.0
// ------------------------------------------------------------------------
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [CNTW-1:0] C_LAST = CNTW'(WIDTH - 1);

  state_t           r_state, w_next, w_start_st;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic             r_qsign, r_rsign;
  logic             w_accept, w_zero, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;
  logic [WIDTH:0]   w_rem_sh, w_diff;

  assign w_accept = start & ~cancel & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_zero   = (b == '0);
  assign w_a_neg  = signed_div & a[WIDTH-1];
  assign w_b_neg  = signed_div & b[WIDTH-1];
  // Zero divisor keeps the raw dividend so the remainder comes out as a itself.
  assign w_a_abs  = (w_a_neg & ~w_zero) ? -a : a;
  assign w_b_abs  = w_b_neg ? -b : b;
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};

`ifdef DIV_ZERO_FAST_EN
  assign w_start_st = w_zero ? ST_FIX : ST_RUN;
`else
  assign w_start_st = ST_RUN;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_start_st;
      ST_RUN: begin
        busy = 1'b1;
        if (cancel)                 w_next = ST_IDLE;
        else if (r_cnt == C_LAST)   w_next = ST_FIX;
      end
      ST_FIX: begin
        busy   = 1'b1;
        w_next = cancel ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = w_accept ? w_start_st : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_dvs   <= w_b_abs;
            r_qsign <= (w_a_neg ^ w_b_neg) & ~w_zero;
            r_rsign <= w_a_neg & ~w_zero;
`ifdef DIV_ZERO_FAST_EN
            if (w_zero) begin
              r_rem <= a;
              r_quo <= '1;
            end else begin
`else
            begin
`endif
              r_rem <= '0;
              r_quo <= w_a_abs;
            end
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + CNTW'(1);
          // Top bit of the trial difference is the borrow: set means restore.
          if (!w_diff[WIDTH]) begin
            r_rem <= w_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_rem_sh[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
        end
        ST_FIX: begin
          if (!cancel) begin
            lo <= r_qsign ? -r_quo : r_quo;
            hi <= r_rsign ? -r_rem : r_rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iter_divider.sv
`default_nettype none
// Directed-vector bench for iter_divider: results, latency, busy window, cancel, reset.
module tb_iter_divider;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst, start, signed_div, cancel;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;
  int          n_cmp = 0;
  int          n_err = 0;

  iter_divider #(.WIDTH(32), .CNTW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .a(a), .b(b), .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then scramble operands to catch re-sampling.
  task automatic launch(input logic sd, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; signed_div = sd; a = av; b = bv;
    step();
    start = 1'b0; signed_div = ~sd; a = 32'h0000_DEAD; b = 32'h0000_0003;
  endtask

  task automatic wait_done(input int cyc0, input int limit, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int c = cyc0; c <= limit; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (busy) bcnt++;
      step();
    end
  endtask

  task automatic do_div(input string tag, input logic sd, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] elo,
                        input logic [31:0] ehi, input int elat);
    int lat, bcnt;
    launch(sd, av, bv);
    check({tag, "_busy1"}, 32'(busy), 32'd1);
    wait_done(1, 100, lat, bcnt);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_bcnt"}, 32'(bcnt), 32'(elat - 1));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_hi"}, hi, ehi);
  endtask

  initial begin
    int lat, bcnt, ndone, nbusy;
    rst = 1'b0; start = 1'b0; signed_div = 1'b0; cancel = 1'b0; a = '0; b = '0;
    #3 rst = 1'b1;
    step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    step();
    rst = 1'b0;
    step();

    do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34);
    // Issued in the DONE cycle of the previous division.
    do_div("b2b_sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    step();
    do_div("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34);
    do_div("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 34);
    do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34);
    do_div("u_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34);
    do_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 34);
    step();
    do_div("u_zero", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, ZLAT);
    do_div("s_zero", 1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0, ZLAT);

    // Second start inside the busy window must be ignored.
    step();
    launch(1'b0, 32'd1000, 32'd10);
    for (int i = 0; i < 9; i++) step();
    start = 1'b1; signed_div = 1'b1; a = 32'd5; b = 32'd5;
    step();
    start = 1'b0;
    wait_done(11, 100, lat, bcnt);
    check("ign_lat", 32'(lat), 32'd34);
    check("ign_bcnt", 32'(bcnt), 32'd23);
    check("ign_lo", lo, 32'd100);
    check("ign_hi", hi, 32'd0);

    do_div("pre_cancel", 1'b0, 32'd50, 32'd3, 32'd16, 32'd2, 34);
    step();
    launch(1'b0, 32'd99, 32'd4);
    for (int i = 0; i < 14; i++) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_busy16", 32'(busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      step();
    end
    check("cancel_no_done", 32'(ndone), 32'd0);
    check("cancel_lo_kept", lo, 32'd16);
    check("cancel_hi_kept", hi, 32'd2);

    start = 1'b1; cancel = 1'b1; signed_div = 1'b0; a = 32'd8; b = 32'd2;
    step();
    start = 1'b0; cancel = 1'b0;
    check("stcan_busy", 32'(busy), 32'd0);
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      if (busy) nbusy++;
      step();
    end
    check("stcan_no_done", 32'(ndone), 32'd0);
    check("stcan_no_busy", 32'(nbusy), 32'd0);
    check("stcan_lo_kept", lo, 32'd16);

    launch(1'b0, 32'd9, 32'd4);
    for (int i = 0; i < 19; i++) step();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    step();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      step();
    end
    check("arst_no_done", 32'(ndone), 32'd0);

    do_div("post_rst", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
